hazard_stall_unit: RTL
======================

Name: hazard_stall_unit

Overview:
- Stall/flush controller for the 5-stage MIPS pipeline; works alongside forwarding in EX.
- Forwarding resolves ALU-to-ALU dependences. This block handles the cases forwarding cannot:
  - load-use hazards (1-cycle bubble);
  - taken branches resolved in EX (flush IF/ID and ID/EX);
  - data-memory wait states (freeze the whole pipeline), with a timeout.
- Keeps stall and flush event counters for performance debugging.

Parameters:
- MEM_TIMEOUT, 255: max consecutive dmem wait cycles before timeout is declared.
- CNT_W, 32: width of the event counters.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- id_rs  in  5  rs field of instruction in ID.
- id_rt  in  5  rt field of instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_ex_memread  in  1  instruction in EX is a load.
- id_ex_rt  in  5  destination of the load in EX.
- ex_branch_taken  in  1  branch/jump in EX resolved taken.
- ex_mem_memreq  in  1  instruction in MEM accesses dmem.
- dmem_ready  in  1  dmem completes the access this cycle.
- pc_write  out  1  PC load enable.
- if_id_write  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID cleared to NOP.
- id_ex_write  out  1  ID/EX load enable.
- id_ex_flush  out  1  ID/EX cleared to bubble.
- ex_mem_write  out  1  EX/MEM load enable.
- mem_wb_flush  out  1  MEM/WB loads a bubble.
- mem_timeout  out  1  sticky timeout flag.
- stall_cycles  out  CNT_W  count of cycles with pc_write=0.
- flush_count  out  CNT_W  count of taken-branch flushes.

Behaviour:
- Decided: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values:
  - state=RUN, wait_cnt=0, mem_timeout=0, stall_cycles=0, flush_count=0.
  - While rst_n=0, all enables are 0 and all flushes are 0.
- Hazard terms (combinational):
  - load_use = id_ex_memread & (id_ex_rt!=0) & ((id_uses_rs & id_ex_rt==id_rs) | (id_uses_rt & id_ex_rt==id_rt)).
  - mem_busy = ex_mem_memreq & ~dmem_ready.
- Outputs are Mealy (combinational from state plus inputs). Default: all enables=1, all flushes=0.
- Priority per cycle is HALT > mem_busy > ex_branch_taken > load_use:
  - HALT: all enables=0, all flushes=0. Pipeline is frozen until reset.
  - mem_busy:
    - pc_write, if_id_write, id_ex_write, ex_mem_write = 0; mem_wb_flush=1.
    - Any branch or load_use is held, not acted on. EX is frozen, so both are re-evaluated on release.
  - ex_branch_taken (no mem_busy):
    - if_id_flush=1, id_ex_flush=1, pc_write=1 (the target is loaded).
    - load_use is ignored because the ID instruction is squashed.
  - load_use only: pc_write=0, if_id_write=0, id_ex_flush=1.
    - Exactly 1 bubble. Next cycle the load is in MEM and forwarding covers the dependence.
- FSM states: RUN, MEM_WAIT, HALT.
  - RUN, mem_busy: go to MEM_WAIT, wait_cnt<=1.
  - MEM_WAIT, dmem_ready=1: go to RUN, wait_cnt<=0. Pipeline releases in that same cycle (mem_busy=0).
  - MEM_WAIT, mem_busy and wait_cnt==MEM_TIMEOUT: go to HALT, mem_timeout<=1. Otherwise wait_cnt++.
  - MEM_WAIT, ex_mem_memreq dropped: go to RUN (protocol error, tolerated).
  - HALT exits only on reset.
- Timing: dmem_ready and mem_busy are sampled each cycle. A 1-cycle ready in RUN never enters MEM_WAIT.
- Counters:
  - stall_cycles increments on every cycle with rst_n=1 and pc_write=0, HALT included.
  - flush_count increments on cycles where if_id_flush=1.
  - Both wrap modulo 2^CNT_W silently.
- Simultaneous events: mem_busy together with ex_branch_taken and load_use produces a freeze only. The flush is applied on the first non-busy cycle.
- Register 0: a load to $0 never causes a stall.
- Reset mid-MEM_WAIT: immediate return to RUN with counters cleared. No output glitch is required beyond asynchronous clear.

Decomposition:
- Shared package (mips_pkg):
  - state enum RUN/MEM_WAIT/HALT;
  - REG_ZERO=5'd0;
  - register-index width constant (5).
- Sub-module hazard_event_counter (CNT_W-bit enable counter with async active-low clear), instantiated twice.
- The load_use and priority logic stays in the top module.

Test Plan:
- Load-use: id_ex_memread=1, id_ex_rt=8, id_rs=8, id_uses_rs=1 -> one cycle with pc_write=0, if_id_write=0, id_ex_flush=1; stall_cycles=1; next cycle (memread=0) all enables=1.
- Load to $0: id_ex_rt=0, id_rs=0, memread=1 -> no stall; stall_cycles stays 0.
- Branch plus load_use in the same cycle -> if_id_flush=1, id_ex_flush=1, pc_write=1; flush_count=1, stall_cycles=0.
- Dmem wait: ex_mem_memreq=1, dmem_ready low 3 cycles then high -> 3 freeze cycles (ex_mem_write=0, mem_wb_flush=1), release on cycle 4; stall_cycles=3; state back to RUN.
- Timeout: MEM_TIMEOUT=4, dmem_ready held 0 -> mem_timeout=1 after 5 busy cycles; HALT holds all enables 0; rst_n pulse low clears everything mid-HALT.
- Freeze with pending branch: ex_branch_taken=1 during mem_busy for 2 cycles -> no flush while busy; exactly one flush on the release cycle; flush_count=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline hazard logic.
// Holds the hazard FSM state encoding and register-file index definitions.
package mips_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

endpackage

// File: rtl/hazard_event_counter.sv
// Free-running event counter: +1 on each enabled cycle, wraps silently.
// Latency: count visible the cycle after the event; asynchronously cleared by rst_n.
module hazard_event_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller: load-use bubbles, taken-branch flushes, dmem freeze with timeout.
// Outputs are combinational from state and inputs; a stuck dmem parks the pipeline in HALT.
module hazard_stall_unit
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_ex_memread,
  input  logic [REG_W-1:0] id_ex_rt,
  input  logic             ex_branch_taken,
  input  logic             ex_mem_memreq,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic             mem_wb_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WCW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_t         r_state, w_state_nxt;
  logic [WCW-1:0] r_wait_cnt, w_wait_cnt_nxt;
  logic           r_mem_timeout, w_timeout_nxt;
  logic           w_load_use;
  logic           w_mem_busy;

  assign w_load_use = id_ex_memread && (id_ex_rt != REG_ZERO) &&
                      ((id_uses_rs && (id_ex_rt == id_rs)) ||
                       (id_uses_rt && (id_ex_rt == id_rt)));
  assign w_mem_busy = ex_mem_memreq && !dmem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_mem_timeout <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_timeout_nxt  = r_mem_timeout;
    case (r_state)
      RUN: begin
        if (w_mem_busy) begin
          w_state_nxt    = MEM_WAIT;
          w_wait_cnt_nxt = WCW'(1);
        end
      end
      MEM_WAIT: begin
        // A dropped request is treated like completion rather than an error.
        if (!w_mem_busy) begin
          w_state_nxt    = RUN;
          w_wait_cnt_nxt = '0;
        end else if (r_wait_cnt == WCW'(MEM_TIMEOUT)) begin
          w_state_nxt   = HALT;
          w_timeout_nxt = 1'b1;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 1'b1;
        end
      end
      HALT: begin
        w_state_nxt = HALT;
      end
      default: begin
        w_state_nxt    = RUN;
        w_wait_cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    if (!rst_n || (r_state == HALT)) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
    end else if (w_mem_busy) begin
      // Branch and load-use stay pending in frozen EX and are re-evaluated on release.
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (w_load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  assign mem_timeout = r_mem_timeout;

  hazard_event_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (!pc_write),
    .o_cnt (stall_cycles)
  );

  hazard_event_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (if_id_flush),
    .o_cnt (flush_count)
  );

endmodule
